// File: rtl/axi_wresp_tracker.sv
// AXI write-response (B channel) tracker: counts outstanding writes, consumes B beats,
// and returns a one-cycle data_ok per completed write. Optional watchdog under WRESP_TIMEOUT_EN.
module axi_wresp_tracker #(
  parameter int unsigned MAX_OUT     = 4,
  parameter int unsigned CNT_W       = 3,
  parameter logic [3:0]  EXP_BID     = 4'd1
`ifdef WRESP_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1023
`endif
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_issue,
  output logic             wr_full,
  output logic             wr_idle,
  output logic [CNT_W-1:0] outstanding,
  input  logic [3:0]       bid,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready,
  output logic             data_ok,
  output logic             resp_err,
  output logic             ovf_err,
  output logic             timeout
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             fire;
  logic             full;
  logic             issue_acc;
  logic             b_err;

  assign fire      = bvalid && bready;
  assign full      = (cnt == CNT_W'(MAX_OUT));
  // An issue at full is only absorbed when a completion frees a slot on the same edge.
  assign issue_acc = wr_issue && (!full || fire);
  assign b_err     = bresp[1] || (bid != EXP_BID);

  assign outstanding = cnt;
  assign wr_full     = full;
  assign wr_idle     = (cnt == '0);

  // Next count and next state.
  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    case ({issue_acc, fire})
      2'b10:   cnt_nxt = cnt + CNT_W'(1);
      2'b01:   cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
    case (state)
      ST_IDLE: if (issue_acc) state_nxt = ST_WAIT;
      ST_WAIT: if (fire && !issue_acc && (cnt == CNT_W'(1))) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bready   <= 1'b0;
      data_ok  <= 1'b0;
      resp_err <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bready   <= (state_nxt == ST_WAIT);
      data_ok  <= fire;
      resp_err <= fire && b_err;
      if (wr_issue && full && !fire) ovf_err <= 1'b1;
    end
  end

`ifdef WRESP_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  logic [15:0] wdog, wdog_nxt;

  // Watchdog counts WAIT cycles without a completion and saturates at the limit.
  always_comb begin
    wdog_nxt = wdog;
    if ((state == ST_IDLE) || fire) wdog_nxt = '0;
    else if (wdog != TO_LIM)        wdog_nxt = wdog + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      wdog <= wdog_nxt;
      if (wdog_nxt == TO_LIM) timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wresp_tracker.sv
// Bench for axi_wresp_tracker: cycle model plus a response scoreboard for data_ok/resp_err.
module tb_axi_wresp_tracker;

  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TO_CYC  = 8;

  logic             clk;
  logic             resetn;
  logic             wr_issue;
  logic             wr_full;
  logic             wr_idle;
  logic [CNT_W-1:0] outstanding;
  logic [3:0]       bid;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;
  logic             data_ok;
  logic             resp_err;
  logic             ovf_err;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  axi_wresp_tracker #(
    .MAX_OUT(MAX_OUT),
    .CNT_W(CNT_W),
    .EXP_BID(4'd1)
`ifdef WRESP_TIMEOUT_EN
    , .TIMEOUT_CYC(TO_CYC)
`endif
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .wr_issue(wr_issue),
    .wr_full(wr_full),
    .wr_idle(wr_idle),
    .outstanding(outstanding),
    .bid(bid),
    .bresp(bresp),
    .bvalid(bvalid),
    .bready(bready),
    .data_ok(data_ok),
    .resp_err(resp_err),
    .ovf_err(ovf_err),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, advanced on each rising edge.
  int   m_cnt;
  logic m_bready;
  logic m_ovf;
  logic m_dok;
  logic m_to;
  int   m_wd;
  int   n_dok;
  logic exp_q[$];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt = 0; m_bready = 1'b0; m_ovf = 1'b0; m_dok = 1'b0;
      m_to = 1'b0; m_wd = 0;
      exp_q.delete();
    end else begin
      logic f;
      f = bvalid && m_bready;
      if (f) exp_q.push_back(bresp[1] || (bid != 4'd1));
`ifdef WRESP_TIMEOUT_EN
      if (!m_bready || f) m_wd = 0;
      else if (m_wd < int'(TO_CYC)) m_wd++;
      if (m_wd == int'(TO_CYC)) m_to = 1'b1;
`endif
      if (wr_issue && (m_cnt == int'(MAX_OUT)) && !f) m_ovf = 1'b1;
      else m_cnt = m_cnt + (wr_issue ? 1 : 0) - (f ? 1 : 0);
      m_bready = (m_cnt != 0);
      m_dok = f;
    end
  end

  // Compare against the model mid-cycle; pop the scoreboard on every data_ok.
  always @(negedge clk) begin
    chk("outstanding", 32'(outstanding), 32'(m_cnt));
    chk("bready", 32'(bready), 32'(m_bready));
    chk("wr_full", 32'(wr_full), 32'(m_cnt == int'(MAX_OUT)));
    chk("wr_idle", 32'(wr_idle), 32'(m_cnt == 0));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("data_ok", 32'(data_ok), 32'(m_dok));
    if (data_ok === 1'b1) begin
      n_dok++;
      if (exp_q.size() == 0) chk("dok_unexpected", 32'(1), 32'(0));
      else chk("resp_err", 32'(resp_err), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic b_beat(input logic [3:0] id, input logic [1:0] rsp);
    bvalid = 1'b1; bid = id; bresp = rsp;
    tick();
    bvalid = 1'b0; bid = 4'd1; bresp = 2'b00;
  endtask

  initial begin
    int base;
    n_dok = 0;
    resetn = 1'b0; wr_issue = 1'b0; bvalid = 1'b0; bid = 4'd1; bresp = 2'b00;
    tick(2);
    chk("rst_outstanding", 32'(outstanding), 32'(0));
    chk("rst_bready", 32'(bready), 32'(0));
    chk("rst_idle", 32'(wr_idle), 32'(1));
    #2 resetn = 1'b1;
    tick(2);

    // Single write, B three cycles later.
    wr_issue = 1'b1; tick(); wr_issue = 1'b0;
    chk("t1_bready", 32'(bready), 32'(1));
    tick(2);
    b_beat(4'd1, 2'b00);
    chk("t1_dok", 32'(data_ok), 32'(1));
    chk("t1_err", 32'(resp_err), 32'(0));
    chk("t1_idle", 32'(wr_idle), 32'(1));
    tick();
    chk("t1_dok_low", 32'(data_ok), 32'(0));

    // Fill to MAX_OUT, overflow, drain back-to-back.
    wr_issue = 1'b1; tick(4);
    chk("t2_full", 32'(wr_full), 32'(1));
    tick(); wr_issue = 1'b0;
    chk("t2_ovf", 32'(ovf_err), 32'(1));
    chk("t2_cnt", 32'(outstanding), 32'(4));
    base = n_dok;
    bvalid = 1'b1; tick(4); bvalid = 1'b0;
    tick(2);
    chk("t2_ndok", 32'(n_dok - base), 32'(4));
    chk("t2_idle", 32'(wr_idle), 32'(1));

    // Issue and fire on the same edge at count 2.
    wr_issue = 1'b1; tick(2);
    bvalid = 1'b1; tick(); wr_issue = 1'b0; bvalid = 1'b0;
    chk("t3_cnt", 32'(outstanding), 32'(2));
    chk("t3_dok", 32'(data_ok), 32'(1));
    tick();
    chk("t3_dok_once", 32'(data_ok), 32'(0));
    bvalid = 1'b1; tick(2); bvalid = 1'b0;
    tick();

    // Error responses (SLVERR, bad id) then EXOKAY.
    wr_issue = 1'b1; tick(3); wr_issue = 1'b0;
    b_beat(4'd1, 2'b10);
    chk("t4_slverr", 32'(resp_err), 32'(1));
    b_beat(4'd3, 2'b00);
    chk("t4_badid", 32'(resp_err), 32'(1));
    b_beat(4'd1, 2'b01);
    chk("t4_exokay", 32'(resp_err), 32'(0));
    chk("t4_dok", 32'(data_ok), 32'(1));
    tick();

    // bvalid while idle is never accepted.
    bvalid = 1'b1; tick(3);
    chk("t5_bready", 32'(bready), 32'(0));
    chk("t5_dok", 32'(data_ok), 32'(0));
    chk("t5_cnt", 32'(outstanding), 32'(0));
    bvalid = 1'b0;

    // Asynchronous reset with three outstanding.
    wr_issue = 1'b1; tick(3); wr_issue = 1'b0;
    chk("t6_pre", 32'(outstanding), 32'(3));
    #2 resetn = 1'b0;
    #1;
    chk("t6_cnt", 32'(outstanding), 32'(0));
    chk("t6_bready", 32'(bready), 32'(0));
    chk("t6_ovf", 32'(ovf_err), 32'(0));
    chk("t6_dok", 32'(data_ok), 32'(0));
    chk("t6_err", 32'(resp_err), 32'(0));
    chk("t6_to", 32'(timeout), 32'(0));
    tick();
    #2 resetn = 1'b1;
    bvalid = 1'b1; tick(3); bvalid = 1'b0;
    chk("t6_noacc", 32'(outstanding), 32'(0));
    chk("t6_nodok", 32'(data_ok), 32'(0));

    // Watchdog: one write, no response.
    wr_issue = 1'b1; tick(); wr_issue = 1'b0;
    tick(TO_CYC - 1);
    chk("t7_to_early", 32'(timeout), 32'(0));
    tick();
`ifdef WRESP_TIMEOUT_EN
    chk("t7_to", 32'(timeout), 32'(1));
`else
    chk("t7_to", 32'(timeout), 32'(0));
`endif
    b_beat(4'd1, 2'b00);
    tick(2);
    chk("t7_idle", 32'(wr_idle), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
